boundary_detect: RTL and testbench

- Producer side of the corner/scale interface consumed by the image overlay stage.
- Scans the incoming camera pixel stream, classifies marker-coloured pixels, and tracks four extreme corners per frame.
- At end of frame it publishes top_left/top_right/bot_left/bot_right coordinates and scale_dist, the squared top-edge length, with a one-cycle valid strobe.

---
 rtl/boundary_detect_pkg.sv | 68 ++++++
 rtl/boundary_detect_tracker.sv | 61 ++++++
 rtl/boundary_detect.sv | 202 ++++++++++++++++++++
 tb/tb_boundary_detect.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/boundary_detect_pkg.sv
// Shared constants, state encoding and helpers for the boundary_detect block.
// The optional BOUNDARY_SMOOTH_EN build uses coord_avg and ST_SMOOTH.
package boundary_detect_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned SCALE_W  = 23;
  localparam int unsigned METRIC_W = 12;

  localparam int unsigned CORNER_TL = 0;
  localparam int unsigned CORNER_TR = 1;
  localparam int unsigned CORNER_BL = 2;
  localparam int unsigned CORNER_BR = 3;

  localparam logic [METRIC_W-1:0] MIN_S_INIT = 12'hFFF;
  localparam logic [METRIC_W-1:0] MAX_S_INIT = 12'h000;
  localparam logic [METRIC_W-1:0] MAX_D_INIT = 12'h800;
  localparam logic [METRIC_W-1:0] MIN_D_INIT = 12'h7FF;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_SMOOTH  = 2'd1,
    ST_SQUARE  = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  function automatic logic corner_uses_d(input int unsigned c);
    return (c == CORNER_TR) || (c == CORNER_BL);
  endfunction

  function automatic logic corner_is_max(input int unsigned c);
    return (c == CORNER_TR) || (c == CORNER_BR);
  endfunction

  function automatic logic [METRIC_W-1:0] corner_init(input int unsigned c);
    logic [METRIC_W-1:0] v;
    case (c)
      CORNER_TL: v = MIN_S_INIT;
      CORNER_TR: v = MAX_D_INIT;
      CORNER_BL: v = MIN_D_INIT;
      CORNER_BR: v = MAX_S_INIT;
      default:   v = MIN_S_INIT;
    endcase
    return v;
  endfunction

  // Signed metrics are compared by flipping the sign bit into offset-binary.
  function automatic logic metric_beats(input logic [METRIC_W-1:0] cand,
                                        input logic [METRIC_W-1:0] best,
                                        input logic is_signed,
                                        input logic is_max);
    logic [METRIC_W-1:0] kc;
    logic [METRIC_W-1:0] kb;
    if (is_signed) begin
      kc = {~cand[METRIC_W-1], cand[METRIC_W-2:0]};
      kb = {~best[METRIC_W-1], best[METRIC_W-2:0]};
    end else begin
      kc = cand;
      kb = best;
    end
    return is_max ? (kc > kb) : (kc < kb);
  endfunction

  function automatic logic [COORD_W-1:0] coord_avg(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return COORD_W'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

endpackage

// File: rtl/boundary_detect_tracker.sv
// Tracks one extreme (min/max of s=X+Y or d=X-Y) with its coordinates and
// snapshots the merged result at the frame boundary while reloading its init.
module boundary_detect_tracker
  import boundary_detect_pkg::*;
#(
  parameter int unsigned p_corner = CORNER_TL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               upd,
  input  logic               frame_end,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] snap_x,
  output logic [COORD_W-1:0] snap_y
);

  localparam logic                USE_D  = corner_uses_d(p_corner);
  localparam logic                IS_MAX = corner_is_max(p_corner);
  localparam logic [METRIC_W-1:0] INIT   = corner_init(p_corner);

  logic [METRIC_W-1:0] metric_s;
  logic                wins_s;
  logic [METRIC_W-1:0] best_r;
  logic [COORD_W-1:0]  best_x_r, best_y_r, snap_x_r, snap_y_r;

  // Per-pixel metric and strict comparison against the running extreme.
  always_comb begin
    if (USE_D) begin
      metric_s = {1'b0, x} - {1'b0, y};
    end else begin
      metric_s = {1'b0, x} + {1'b0, y};
    end
    wins_s = upd && metric_beats(metric_s, best_r, USE_D, IS_MAX);
  end

  // Accumulate, or at frame end snapshot the merged extreme and restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_r   <= INIT;
      best_x_r <= 11'd0;
      best_y_r <= 11'd0;
      snap_x_r <= 11'd0;
      snap_y_r <= 11'd0;
    end else if (frame_end) begin
      snap_x_r <= wins_s ? x : best_x_r;
      snap_y_r <= wins_s ? y : best_y_r;
      best_r   <= INIT;
      best_x_r <= 11'd0;
      best_y_r <= 11'd0;
    end else if (wins_s) begin
      best_r   <= metric_s;
      best_x_r <= x;
      best_y_r <= y;
    end
  end

  assign snap_x = snap_x_r;
  assign snap_y = snap_y_r;

endmodule

// File: rtl/boundary_detect.sv
// Marker-pixel corner detector publishing four corners and squared top-edge
// length per frame. Optional build macro: BOUNDARY_SMOOTH_EN.
module boundary_detect
  import boundary_detect_pkg::*;
#(
  parameter int          p_screen_width  = 640,
  parameter int          p_screen_height = 480,
  parameter logic [7:0]  p_r_min         = 8'd160,
  parameter logic [7:0]  p_g_max         = 8'd80,
  parameter logic [7:0]  p_b_max         = 8'd80,
  parameter int          p_min_pixels    = 64,
  parameter int          p_count_w       = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] VGA_X,
  input  logic [COORD_W-1:0] VGA_Y,
  input  logic [7:0]         pixel_R,
  input  logic [7:0]         pixel_G,
  input  logic [7:0]         pixel_B,
  output logic [COORD_W-1:0] top_left_x,
  output logic [COORD_W-1:0] top_left_y,
  output logic [COORD_W-1:0] top_right_x,
  output logic [COORD_W-1:0] top_right_y,
  output logic [COORD_W-1:0] bot_left_x,
  output logic [COORD_W-1:0] bot_left_y,
  output logic [COORD_W-1:0] bot_right_x,
  output logic [COORD_W-1:0] bot_right_y,
  output logic [SCALE_W-1:0] scale_dist,
  output logic               marker_found,
  output logic               corners_valid
);

  localparam logic [COORD_W-1:0]   LAST_X  = COORD_W'(p_screen_width - 1);
  localparam logic [COORD_W-1:0]   LAST_Y  = COORD_W'(p_screen_height - 1);
  localparam logic [p_count_w-1:0] CNT_MAX = {p_count_w{1'b1}};
  localparam logic [p_count_w-1:0] MIN_PIX = p_count_w'(p_min_pixels);

  state_t                   state_r, state_next_s;
  logic                     marker_s, eof_s;
  logic [p_count_w-1:0]     cnt_r, cnt_next_s;
  logic                     snap_ok_r;
  logic [3:0][COORD_W-1:0]  snap_x_s, snap_y_s, src_x_s, src_y_s, out_x_r, out_y_r;
  logic [11:0]              dx_s, dy_s, dx_abs_s, dy_abs_s;
  logic [21:0]              dx_sq_r, dy_sq_r;
  logic [SCALE_W-1:0]       scale_r;
  logic                     marker_found_r, corners_valid_r;

  assign marker_s = pixel_valid && (pixel_R >= p_r_min) && (pixel_G <= p_g_max)
                    && (pixel_B <= p_b_max);
  assign eof_s    = pixel_valid && (VGA_X == LAST_X) && (VGA_Y == LAST_Y)
                    && (state_r == ST_SCAN);

  for (genvar i = 0; i < 4; i++) begin : g_corner
    boundary_detect_tracker #(.p_corner(i)) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .upd       (marker_s),
      .frame_end (eof_s),
      .x         (VGA_X),
      .y         (VGA_Y),
      .snap_x    (snap_x_s[i]),
      .snap_y    (snap_y_s[i])
    );
  end

`ifdef BOUNDARY_SMOOTH_EN
  localparam state_t ST_AFTER_EOF = ST_SMOOTH;
  logic [3:0][COORD_W-1:0] sm_x_r, sm_y_r;

  // Average with the last published corners; a fresh lock loads raw values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sm_x_r <= '0;
      sm_y_r <= '0;
    end else if (state_r == ST_SMOOTH) begin
      for (int i = 0; i < 4; i++) begin
        sm_x_r[i] <= marker_found_r ? coord_avg(out_x_r[i], snap_x_s[i]) : snap_x_s[i];
        sm_y_r[i] <= marker_found_r ? coord_avg(out_y_r[i], snap_y_s[i]) : snap_y_s[i];
      end
    end
  end

  assign src_x_s = sm_x_r;
  assign src_y_s = sm_y_r;
`else
  localparam state_t ST_AFTER_EOF = ST_SQUARE;
  assign src_x_s = snap_x_s;
  assign src_y_s = snap_y_s;
`endif

  // Frame pipeline sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_SCAN: begin
        if (eof_s) begin
          state_next_s = ST_AFTER_EOF;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_SMOOTH:  state_next_s = ST_SQUARE;
      ST_SQUARE:  state_next_s = ST_PUBLISH;
      ST_PUBLISH: state_next_s = ST_SCAN;
      default:    state_next_s = ST_SCAN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Saturating marker count; the frame-end pixel is merged into the decision.
  always_comb begin
    if (marker_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + p_count_w'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Marker count register and latched validity of the snapshotted frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      snap_ok_r <= 1'b0;
    end else if (eof_s) begin
      cnt_r     <= '0;
      snap_ok_r <= (cnt_next_s >= MIN_PIX);
    end else begin
      cnt_r     <= cnt_next_s;
    end
  end

  // Top-edge deltas; magnitudes keep the squares unsigned.
  always_comb begin
    dx_s = {1'b0, src_x_s[CORNER_TR]} - {1'b0, src_x_s[CORNER_TL]};
    dy_s = {1'b0, src_y_s[CORNER_TR]} - {1'b0, src_y_s[CORNER_TL]};
    if (dx_s[11]) begin
      dx_abs_s = 12'd0 - dx_s;
    end else begin
      dx_abs_s = dx_s;
    end
    if (dy_s[11]) begin
      dy_abs_s = 12'd0 - dy_s;
    end else begin
      dy_abs_s = dy_s;
    end
  end

  // Square the deltas one cycle before publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx_sq_r <= 22'd0;
      dy_sq_r <= 22'd0;
    end else if (state_r == ST_SQUARE) begin
      dx_sq_r <= {10'd0, dx_abs_s} * {10'd0, dx_abs_s};
      dy_sq_r <= {10'd0, dy_abs_s} * {10'd0, dy_abs_s};
    end
  end

  // Publish registers; an undersized frame holds the previous corners.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_x_r         <= '0;
      out_y_r         <= '0;
      scale_r         <= 23'd0;
      marker_found_r  <= 1'b0;
      corners_valid_r <= 1'b0;
    end else if (state_r == ST_PUBLISH) begin
      corners_valid_r <= 1'b1;
      marker_found_r  <= snap_ok_r;
      if (snap_ok_r) begin
        out_x_r <= src_x_s;
        out_y_r <= src_y_s;
        scale_r <= {1'b0, dx_sq_r} + {1'b0, dy_sq_r};
      end
    end else begin
      corners_valid_r <= 1'b0;
    end
  end

  assign top_left_x    = out_x_r[CORNER_TL];
  assign top_left_y    = out_y_r[CORNER_TL];
  assign top_right_x   = out_x_r[CORNER_TR];
  assign top_right_y   = out_y_r[CORNER_TR];
  assign bot_left_x    = out_x_r[CORNER_BL];
  assign bot_left_y    = out_y_r[CORNER_BL];
  assign bot_right_x   = out_x_r[CORNER_BR];
  assign bot_right_y   = out_y_r[CORNER_BR];
  assign scale_dist    = scale_r;
  assign marker_found  = marker_found_r;
  assign corners_valid = corners_valid_r;

endmodule

// File: tb/tb_boundary_detect.sv
// Directed bench for boundary_detect: table of frames plus hand-written
// sequences for single-pixel, reset and frame-boundary corner cases.
module tb_boundary_detect;

  typedef struct packed { logic [10:0] x0, y0, x1, y1; } rect_t;
  typedef struct packed { logic [10:0] tlx, tly, trx, tr_y, blx, bly, brx, bry; } corn_t;
  typedef struct {
    rect_t r [3];
    int    nrect;
    corn_t c;
    int    scale;
    bit    mf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic [10:0] vga_x = 11'd0, vga_y = 11'd0;
  logic [7:0]  pr = 8'd0, pg = 8'd0, pb = 8'd0;

  logic [10:0] tlx, tly, trx, tr_y, blx, bly, brx, bry;
  logic [22:0] scale;
  logic        mf, cv;
  logic [10:0] d1_tlx, d1_tly, d1_trx, d1_try, d1_blx, d1_bly, d1_brx, d1_bry;
  logic [22:0] d1_scale;
  logic        d1_mf, d1_cv;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  boundary_detect dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .VGA_X(vga_x), .VGA_Y(vga_y),
    .pixel_R(pr), .pixel_G(pg), .pixel_B(pb),
    .top_left_x(tlx), .top_left_y(tly), .top_right_x(trx), .top_right_y(tr_y),
    .bot_left_x(blx), .bot_left_y(bly), .bot_right_x(brx), .bot_right_y(bry),
    .scale_dist(scale), .marker_found(mf), .corners_valid(cv)
  );

  boundary_detect #(.p_min_pixels(1)) dut1 (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .VGA_X(vga_x), .VGA_Y(vga_y),
    .pixel_R(pr), .pixel_G(pg), .pixel_B(pb),
    .top_left_x(d1_tlx), .top_left_y(d1_tly), .top_right_x(d1_trx), .top_right_y(d1_try),
    .bot_left_x(d1_blx), .bot_left_y(d1_bly), .bot_right_x(d1_brx), .bot_right_y(d1_bry),
    .scale_dist(d1_scale), .marker_found(d1_mf), .corners_valid(d1_cv)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cv) pulses++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input bit red);
    pixel_valid = 1'b1;
    vga_x = 11'(x);
    vga_y = 11'(y);
    pr = red ? 8'd200 : 8'd0;
    pg = red ? 8'd20 : 8'd0;
    pb = red ? 8'd30 : 8'd0;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic rect(input rect_t r);
    for (int y = int'(r.y0); y <= int'(r.y1); y++)
      for (int x = int'(r.x0); x <= int'(r.x1); x++)
        pix(x, y, 1'b1);
  endtask

  task automatic eof();
    pix(639, 479, 1'b0);
  endtask

  task automatic wait_pulse(input string tag, input int exp_lat);
    int lat;
    bit seen;
    lat = -1;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (cv) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check({tag, ".latency"}, lat, exp_lat);
    @(posedge clk);
    #1;
    check({tag, ".pulse_width"}, int'(cv), 0);
  endtask

  task automatic check_out(input string tag, input corn_t e, input int es, input bit emf);
    check({tag, ".tl_x"}, int'(tlx), int'(e.tlx));
    check({tag, ".tl_y"}, int'(tly), int'(e.tly));
    check({tag, ".tr_x"}, int'(trx), int'(e.trx));
    check({tag, ".tr_y"}, int'(tr_y), int'(e.tr_y));
    check({tag, ".bl_x"}, int'(blx), int'(e.blx));
    check({tag, ".bl_y"}, int'(bly), int'(e.bly));
    check({tag, ".br_x"}, int'(brx), int'(e.brx));
    check({tag, ".br_y"}, int'(bry), int'(e.bry));
    check({tag, ".scale"}, int'(scale), es);
    check({tag, ".marker_found"}, int'(mf), int'(emf));
  endtask

  vec_t vecs [4];
  int base;

  initial begin
    vecs[0].nrect = 1;
    vecs[0].r[0]  = '{11'd200, 11'd100, 11'd263, 11'd163};
    vecs[0].c     = '{11'd200, 11'd100, 11'd263, 11'd100, 11'd200, 11'd163, 11'd263, 11'd163};
    vecs[0].scale = 3969;
    vecs[0].mf    = 1'b1;
    vecs[1].nrect = 1;
    vecs[1].r[0]  = '{11'd300, 11'd300, 11'd309, 11'd300};
    vecs[1].c     = vecs[0].c;
    vecs[1].scale = 3969;
    vecs[1].mf    = 1'b0;
    vecs[2].nrect = 3;
    vecs[2].r[0]  = '{11'd639, 11'd0, 11'd639, 11'd0};
    vecs[2].r[1]  = '{11'd300, 11'd250, 11'd361, 11'd250};
    vecs[2].r[2]  = '{11'd0, 11'd479, 11'd0, 11'd479};
    vecs[2].c     = '{11'd0, 11'd479, 11'd639, 11'd0, 11'd0, 11'd479, 11'd639, 11'd0};
    vecs[2].scale = 637762;
    vecs[2].mf    = 1'b1;
    vecs[3].nrect = 0;
    vecs[3].c     = vecs[2].c;
    vecs[3].scale = 637762;
    vecs[3].mf    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.tl_x", int'(tlx), 0);
    check("reset.br_y", int'(bry), 0);
    check("reset.scale", int'(scale), 0);
    check("reset.marker_found", int'(mf), 0);
    check("reset.corners_valid", int'(cv), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single pixel: only the p_min_pixels=1 instance accepts it.
    pix(100, 50, 1'b1);
    eof();
    wait_pulse("single", 2);
    check("single.d1_tl_x", int'(d1_tlx), 100);
    check("single.d1_tl_y", int'(d1_tly), 50);
    check("single.d1_tr_x", int'(d1_trx), 100);
    check("single.d1_bl_y", int'(d1_bly), 50);
    check("single.d1_br_x", int'(d1_brx), 100);
    check("single.d1_br_y", int'(d1_bry), 50);
    check("single.d1_scale", int'(d1_scale), 0);
    check("single.d1_marker_found", int'(d1_mf), 1);
    check("single.marker_found", int'(mf), 0);
    check("single.tl_x", int'(tlx), 0);

    for (int v = 0; v < 4; v++) begin
      for (int r = 0; r < vecs[v].nrect; r++) rect(vecs[v].r[r]);
      eof();
      wait_pulse($sformatf("vec%0d", v), 2);
      check_out($sformatf("vec%0d", v), vecs[v].c, vecs[v].scale, vecs[v].mf);
    end

    // Reset after the frame-end pixel: the partial result must never appear.
    base = pulses;
    rect('{11'd400, 11'd400, 11'd420, 11'd405});
    eof();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst.pulses", pulses - base, 0);
    check("rst.marker_found", int'(mf), 0);
    check("rst.tl_x", int'(tlx), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst.pulses_idle", pulses - base, 0);
    rect('{11'd10, 11'd10, 11'd19, 11'd19});
    eof();
    wait_pulse("post_rst", 2);
    check("post_rst.pulses", pulses - base, 1);
    check_out("post_rst", '{11'd10, 11'd10, 11'd19, 11'd10, 11'd10, 11'd19, 11'd19, 11'd19}, 81, 1'b1);

    // Marker pixel right after frame end belongs to the next frame.
    rect('{11'd50, 11'd50, 11'd57, 11'd57});
    eof();
    pix(5, 5, 1'b1);
    wait_pulse("next_a", 1);
    check_out("next_a", '{11'd50, 11'd50, 11'd57, 11'd50, 11'd50, 11'd57, 11'd57, 11'd57}, 49, 1'b1);
    rect('{11'd600, 11'd400, 11'd607, 11'd407});
    eof();
    wait_pulse("next_b", 2);
    check_out("next_b", '{11'd5, 11'd5, 11'd607, 11'd400, 11'd5, 11'd5, 11'd607, 11'd407}, 518429, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
